hier_node_ctrl: RTL and testbench

Parametrised hierarchy-tree node controller for generated multi-level module trees. Each node fans a start request out to NUM_CHILDREN child instances, tracks their completions, and reports one aggregated done or error upward, so whole trees are driven from a single root start. Child launch is either parallel or sequential, and the node supports an optional completion watchdog.

---
 rtl/hier_node_pkg.sv | 24 ++
 rtl/hier_node_done_tracker.sv | 38 +++
 rtl/hier_node_ctrl.sv | 115 +++++++++++
 tb/tb_hier_node_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchy-tree node controller.
package hier_node_pkg;

  localparam int MAX_CHILDREN = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE,
    ERR
  } state_e;

  // Index width; never returns 0, so a single-child node still has a 1-bit index.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 6; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hier_node_done_tracker.sv
// Sticky per-child completion mask with accept gating and all-done detect.
// Parallel mode accepts any child; sequential mode accepts only the child at i_idx.
module hier_node_done_tracker
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int SEQ_MODE     = 0,
  parameter int IDX_W        = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_accept_en,
  input  logic [IDX_W-1:0]        i_idx,
  input  logic [NUM_CHILDREN-1:0] i_done,
  output logic [NUM_CHILDREN-1:0] o_mask,
  output logic                    o_all_done
);

  logic [NUM_CHILDREN-1:0] r_mask;
  logic [NUM_CHILDREN-1:0] w_sel;

  always_comb begin
    w_sel = '0;
    if (SEQ_MODE != 0) w_sel[i_idx] = 1'b1;
    else               w_sel = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_mask <= '0;
    else if (i_clr)       r_mask <= '0;
    else if (i_accept_en) r_mask <= r_mask | (i_done & w_sel);
  end

  assign o_mask     = r_mask;
  assign o_all_done = &r_mask;

endmodule

// File: rtl/hier_node_ctrl.sv
// Tree node: fans a start out to its children, aggregates their completions into one done.
// Optional completion watchdog (ERR state, sticky err_o) enabled by HIER_NODE_WATCHDOG_EN.
module hier_node_ctrl
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int SEQ_MODE     = 0,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic [CNT_W-1:0]        timeout_cfg_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [NUM_CHILDREN-1:0] done_mask_o,
  output logic [CNT_W-1:0]        elapsed_o
);

  localparam int IDX_W = clog2_min1(NUM_CHILDREN);

  state_e                  r_state;
  state_e                  w_next;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_elapsed;
  logic [NUM_CHILDREN-1:0] w_mask;
  logic                    w_all_done;
  logic                    w_start_acc;
  logic                    w_advance;
  logic                    w_timeout;

  assign w_start_acc = (r_state == IDLE) && start_i;
  assign w_advance   = (SEQ_MODE != 0) && w_mask[r_idx] &&
                       (r_idx < IDX_W'(NUM_CHILDREN - 1));

`ifdef HIER_NODE_WATCHDOG_EN
  assign w_timeout = (timeout_cfg_i != '0) && (r_elapsed == timeout_cfg_i);
  assign err_o     = (r_state == ERR);
`else
  logic w_unused_wd;
  assign w_unused_wd = ^{clear_i, timeout_cfg_i};
  assign w_timeout   = 1'b0;
  assign err_o       = 1'b0;
`endif

  hier_node_done_tracker #(
    .NUM_CHILDREN(NUM_CHILDREN),
    .SEQ_MODE    (SEQ_MODE),
    .IDX_W       (IDX_W)
  ) u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_start_acc),
    .i_accept_en(r_state == WAIT),
    .i_idx      (r_idx),
    .i_done     (child_done_i),
    .o_mask     (w_mask),
    .o_all_done (w_all_done)
  );

  // Completion outranks a watchdog hit in the same cycle.
  always_comb begin
    w_next        = r_state;
    child_start_o = '0;
    case (r_state)
      IDLE: if (start_i) w_next = LAUNCH;
      LAUNCH: begin
        if (SEQ_MODE != 0) child_start_o[r_idx] = 1'b1;
        else               child_start_o = '1;
        w_next = WAIT;
      end
      WAIT: begin
        if (w_all_done)     w_next = DONE;
        else if (w_advance) w_next = LAUNCH;
        else if (w_timeout) w_next = ERR;
      end
      DONE: w_next = IDLE;
`ifdef HIER_NODE_WATCHDOG_EN
      ERR: if (clear_i) w_next = IDLE;
`else
      ERR: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Elapsed counts WAIT cycles that stay in WAIT, so it freezes on the exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_elapsed <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_idx     <= '0;
        r_elapsed <= '0;
      end else begin
        if (r_state == WAIT && w_next == LAUNCH) r_idx <= r_idx + IDX_W'(1);
        if (r_state == WAIT && w_next == WAIT && r_elapsed != '1)
          r_elapsed <= r_elapsed + CNT_W'(1);
      end
    end
  end

  assign busy_o      = (r_state == LAUNCH) || (r_state == WAIT);
  assign done_o      = (r_state == DONE);
  assign done_mask_o = w_mask;
  assign elapsed_o   = r_elapsed;

endmodule

// File: tb/tb_hier_node_ctrl.sv
// Directed bench: a 5-child parallel node and a 3-child sequential node driven from vector tables.
module tb_hier_node_ctrl;

  typedef struct packed {
    logic        start;
    logic [4:0]  done;
    logic [4:0]  cs;
    logic        busy;
    logic        dn;
    logic [4:0]  mask;
    logic [15:0] el;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_p = 0, clear_p = 0;
  logic [15:0] tcfg_p = '0;
  logic [4:0]  done_p = '0;
  logic [4:0]  cs_p, mask_p;
  logic        busy_p, dn_p, err_p;
  logic [15:0] el_p;

  logic        start_s = 0, clear_s = 0;
  logic [15:0] tcfg_s = '0;
  logic [2:0]  done_s = '0;
  logic [2:0]  cs_s, mask_s;
  logic        busy_s, dn_s, err_s;
  logic [15:0] el_s;

  int checks = 0;
  int failures = 0;

  hier_node_ctrl #(.NUM_CHILDREN(5), .SEQ_MODE(0), .CNT_W(16)) u_par (
    .clk(clk), .rst_n(rst_n), .start_i(start_p), .clear_i(clear_p),
    .timeout_cfg_i(tcfg_p), .child_start_o(cs_p), .child_done_i(done_p),
    .busy_o(busy_p), .done_o(dn_p), .err_o(err_p),
    .done_mask_o(mask_p), .elapsed_o(el_p)
  );

  hier_node_ctrl #(.NUM_CHILDREN(3), .SEQ_MODE(1), .CNT_W(16)) u_seq (
    .clk(clk), .rst_n(rst_n), .start_i(start_s), .clear_i(clear_s),
    .timeout_cfg_i(tcfg_s), .child_start_o(cs_s), .child_done_i(done_s),
    .busy_o(busy_s), .done_o(dn_s), .err_o(err_s),
    .done_mask_o(mask_s), .elapsed_o(el_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [4:0] d, input logic [4:0] cs,
                              input logic b, input logic dn, input logic [4:0] m,
                              input logic [15:0] el);
    vec_t v;
    v.start = st; v.done = d; v.cs = cs; v.busy = b; v.dn = dn; v.mask = m; v.el = el;
    return v;
  endfunction

  // One cycle on the parallel node: drive after the rising edge, sample at the falling edge.
  task automatic step_p(input logic st, input logic clr, input logic [4:0] d);
    @(posedge clk); #1;
    start_p = st; clear_p = clr; done_p = d;
    @(negedge clk);
  endtask

  vec_t tp[19];
  vec_t ts[15];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic any_done;

    // Parallel: main run (children 4,0,2,1,3 at cycles 3,5,6,8,9), then LAUNCH-pulse / WAIT-start run.
    tp[0]  = mk(1, 5'b00000, 5'b00000, 0, 0, 5'b00000, 0);
    tp[1]  = mk(0, 5'b00000, 5'b11111, 1, 0, 5'b00000, 0);
    tp[2]  = mk(0, 5'b00000, 5'b00000, 1, 0, 5'b00000, 0);
    tp[3]  = mk(0, 5'b10000, 5'b00000, 1, 0, 5'b00000, 1);
    tp[4]  = mk(0, 5'b00000, 5'b00000, 1, 0, 5'b10000, 2);
    tp[5]  = mk(0, 5'b00001, 5'b00000, 1, 0, 5'b10000, 3);
    tp[6]  = mk(0, 5'b00100, 5'b00000, 1, 0, 5'b10001, 4);
    tp[7]  = mk(0, 5'b00000, 5'b00000, 1, 0, 5'b10101, 5);
    tp[8]  = mk(0, 5'b00010, 5'b00000, 1, 0, 5'b10101, 6);
    tp[9]  = mk(0, 5'b01000, 5'b00000, 1, 0, 5'b10111, 7);
    tp[10] = mk(0, 5'b00000, 5'b00000, 1, 0, 5'b11111, 8);
    tp[11] = mk(0, 5'b00000, 5'b00000, 0, 1, 5'b11111, 8);
    tp[12] = mk(0, 5'b00000, 5'b00000, 0, 0, 5'b11111, 8);
    tp[13] = mk(1, 5'b00000, 5'b00000, 0, 0, 5'b11111, 8);
    tp[14] = mk(0, 5'b00001, 5'b11111, 1, 0, 5'b00000, 0);
    tp[15] = mk(1, 5'b00000, 5'b00000, 1, 0, 5'b00000, 0);
    tp[16] = mk(0, 5'b11111, 5'b00000, 1, 0, 5'b00000, 1);
    tp[17] = mk(0, 5'b00000, 5'b00000, 1, 0, 5'b11111, 2);
    tp[18] = mk(0, 5'b00000, 5'b00000, 0, 1, 5'b11111, 2);

    // Sequential N=3: stray done[2] while idx=0, then each child done 2 cycles after its start.
    ts[0]  = mk(1, 5'b000, 5'b000, 0, 0, 5'b000, 0);
    ts[1]  = mk(0, 5'b000, 5'b001, 1, 0, 5'b000, 0);
    ts[2]  = mk(0, 5'b100, 5'b000, 1, 0, 5'b000, 0);
    ts[3]  = mk(0, 5'b001, 5'b000, 1, 0, 5'b000, 1);
    ts[4]  = mk(0, 5'b000, 5'b000, 1, 0, 5'b001, 2);
    ts[5]  = mk(0, 5'b000, 5'b010, 1, 0, 5'b001, 2);
    ts[6]  = mk(0, 5'b000, 5'b000, 1, 0, 5'b001, 2);
    ts[7]  = mk(0, 5'b010, 5'b000, 1, 0, 5'b001, 3);
    ts[8]  = mk(0, 5'b000, 5'b000, 1, 0, 5'b011, 4);
    ts[9]  = mk(0, 5'b000, 5'b100, 1, 0, 5'b011, 4);
    ts[10] = mk(0, 5'b000, 5'b000, 1, 0, 5'b011, 4);
    ts[11] = mk(0, 5'b100, 5'b000, 1, 0, 5'b011, 5);
    ts[12] = mk(0, 5'b000, 5'b000, 1, 0, 5'b111, 6);
    ts[13] = mk(0, 5'b000, 5'b000, 0, 1, 5'b111, 6);
    ts[14] = mk(0, 5'b000, 5'b000, 0, 0, 5'b111, 6);

    #1;
    chk("rst cs_p", cs_p, 0);
    chk("rst busy_p", busy_p, 0);
    chk("rst done_p", dn_p, 0);
    chk("rst err_p", err_p, 0);
    chk("rst mask_p", mask_p, 0);
    chk("rst el_p", el_p, 0);
    chk("rst cs_s", cs_s, 0);
    chk("rst busy_s", busy_s, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of WAIT with mask 00101.
    step_p(1, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b00101);
    step_p(0, 0, 5'b00000);
    chk("midrst pre mask", mask_p, 5'b00101);
    chk("midrst pre busy", busy_p, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst cs", cs_p, 0);
    chk("midrst busy", busy_p, 0);
    chk("midrst done", dn_p, 0);
    chk("midrst err", err_p, 0);
    chk("midrst mask", mask_p, 0);
    chk("midrst el", el_p, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      start_p = tp[i].start;
      done_p  = tp[i].done;
      @(negedge clk);
      chk($sformatf("par%0d cs", i), cs_p, tp[i].cs);
      chk($sformatf("par%0d busy", i), busy_p, tp[i].busy);
      chk($sformatf("par%0d done", i), dn_p, tp[i].dn);
      chk($sformatf("par%0d mask", i), mask_p, tp[i].mask);
      chk($sformatf("par%0d elapsed", i), el_p, tp[i].el);
    end
    start_p = 0; done_p = '0;

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      start_s = ts[i].start;
      done_s  = ts[i].done[2:0];
      @(negedge clk);
      chk($sformatf("seq%0d cs", i), cs_s, ts[i].cs[2:0]);
      chk($sformatf("seq%0d busy", i), busy_s, ts[i].busy);
      chk($sformatf("seq%0d done", i), dn_s, ts[i].dn);
      chk($sformatf("seq%0d mask", i), mask_s, ts[i].mask[2:0]);
      chk($sformatf("seq%0d elapsed", i), el_s, ts[i].el);
    end
    start_s = 0; done_s = '0;

    // Watchdog: timeout 10, child 1 never completes.
    tcfg_p = 16'd10;
    any_done = 1'b0;
    step_p(1, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b11101);
    for (int c = 4; c <= 12; c++) begin
      step_p(0, 0, 5'b00000);
      any_done = any_done | dn_p;
    end
    chk("wd c12 busy", busy_p, 1);
    chk("wd c12 err", err_p, 0);
    chk("wd c12 elapsed", el_p, 10);
    chk("wd no early done", any_done, 0);
`ifdef HIER_NODE_WATCHDOG_EN
    step_p(0, 0, 5'b00000);
    chk("wd err set", err_p, 1);
    chk("wd err busy", busy_p, 0);
    chk("wd err done", dn_p, 0);
    chk("wd err elapsed", el_p, 10);
    chk("wd err mask", mask_p, 5'b11101);
    step_p(1, 0, 5'b00010);
    chk("wd start ignored err", err_p, 1);
    chk("wd start ignored busy", busy_p, 0);
    step_p(0, 1, 5'b00000);
    step_p(0, 0, 5'b00000);
    chk("wd cleared err", err_p, 0);
    chk("wd cleared busy", busy_p, 0);
    chk("wd cleared mask", mask_p, 5'b11101);
    step_p(1, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    chk("wd rerun cs", cs_p, 5'b11111);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b11111);
    step_p(0, 0, 5'b00000);
    step_p(0, 0, 5'b00000);
    chk("wd rerun done", dn_p, 1);
    chk("wd rerun err", err_p, 0);
    chk("wd rerun elapsed", el_p, 2);
`else
    step_p(0, 0, 5'b00010);
    chk("nowd c13 err", err_p, 0);
    chk("nowd c13 busy", busy_p, 1);
    chk("nowd c13 elapsed", el_p, 11);
    step_p(0, 0, 5'b00000);
    chk("nowd c14 mask", mask_p, 5'b11111);
    step_p(0, 0, 5'b00000);
    chk("nowd done", dn_p, 1);
    chk("nowd err", err_p, 0);
    chk("nowd elapsed", el_p, 12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
